wb_write_arbiter: RTL and testbench
===================================

# wb_write_arbiter

Write-back arbiter that owns the single register-file write port (write enable, 4-bit destination, 32-bit result). Merges two producers, in-order ALU results and variable-latency load responses, into one registered write per cycle. Buffers displaced ALU results in a small squashable FIFO and exposes per-register pending-write status to the hazard unit. Sits between the MEM/WB pipeline register and the register file.

## Interface
- DATA_W, 32, result width
- REG_AW, 4, register address width
- FIFO_DEPTH, 4, ALU result buffer entries (power of 2, ≥2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result offered this cycle
- alu_dest  in  REG_AW  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU result accepted when alu_valid & alu_ready
- ld_valid  in  1  load response; always accepted, no backpressure
- ld_dest  in  REG_AW  load destination register
- ld_data  in  DATA_W  load data
- wb_en  out  1  register-file write enable (registered)
- wb_dest  out  REG_AW  register-file write address (registered)
- wb_data  out  DATA_W  register-file write data (registered)
- pending_mask  out  2**REG_AW  bit i set while a live FIFO entry targets register i

## Operation
- Selection per cycle, priority order: (1) ld_valid → load; (2) FIFO non-empty → pop head; (3) alu_valid & FIFO empty & !ld_valid → ALU bypass; (4) nothing → wb_en=0.
- Accepted ALU result not selected in that cycle is pushed to FIFO tail.
- alu_ready = (count < FIFO_DEPTH); depends on current count only, so a full FIFO accepts no push even in a cycle it pops.
- Push and pop in the same cycle allowed when not full; count unchanged.
- Squash: ld_valid clears the live bit of every FIFO entry whose dest == ld_dest (queued ALU entries are older than the load). A pushed entry in the same cycle with alu_dest == ld_dest is pushed dead.
- Popping a dead entry consumes the slot: wb_en=0 that cycle, FIFO advances.
- Destination 15 (PC) is never written: selected item with dest 15 yields wb_en=0, still consumed/popped; such entries never set pending_mask.
- pending_mask is an OR over live FIFO entries; bypass and load items never appear in it.
- Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

## Timing
- Reset values: wb_en=0, wb_dest=0, wb_data=0, FIFO empty, alu_ready=1, pending_mask=0.
- Latency: input accepted in cycle N with no contention → wb_en high in cycle N+1; register file commits on falling edge of N+1.
- Queued entry: written the cycle after it reaches head and wins selection.
- Continuous ld_valid starves the FIFO; no fairness guarantee, bounded by load issue rate upstream.
- pending_mask reflects post-edge FIFO state (updates same edge as push/squash/pop).
- rst asserted mid-operation discards all queued entries and clears outputs immediately, without waiting for a clock edge.

## Configuration
- WB_PENDING_MASK_EN defined: per-entry dest compare logic and pending_mask as specified.
- Undefined: pending_mask tied to all-zeros, compare logic omitted; squash logic retained.

## Structure
- Shared package wb_pkg: DATA_W, REG_AW defaults, PC_REG = 4'd15, typedef wb_entry_t {live, dest, data}.
- One sub-module: wb_squash_fifo (storage, pointers, count, squash-by-dest, optional pending_mask); arbitration and output registers stay in top.

## Test plan
- Reset: assert rst mid-stream with 3 entries queued → wb_en=0, alu_ready=1, pending_mask=0 immediately; no writes after release.
- Bypass: alu_valid, dest=3, data=0xDEAD_BEEF, FIFO empty → next cycle wb_en=1, wb_dest=3, wb_data=0xDEADBEEF.
- Contention: ld_valid (R1, 0x11) and alu_valid (R2, 0x22) same cycle → R1 written cycle N+1, R2 at N+2; pending_mask=0x0004 during N+1.
- Full: ld_valid held 6 cycles with ALU offering every cycle → alu_ready drops after 4 pushes; FIFO drains R-order after load stops.
- Squash: queue ALU R5=0x55, then ld R5=0xAA → R5 written 0xAA; dead slot gives one wb_en=0 cycle; pending_mask bit 5 cleared.
- PC drop: alu_valid dest=15 → item consumed, wb_en stays 0, pending_mask unaffected.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared constants and types for the write-back arbiter slice.
//            Default result/address widths, the PC register index (never
//            written through the register-file port) and the queued-entry
//            record layout.
// Revision : 1.0  initial release
// ============================================================================
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_REG_AW = 4;

    localparam logic [3:0] PC_REG = 4'd15;

    typedef struct packed {
        logic                 live;
        logic [WB_REG_AW-1:0] dest;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_squash_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_squash_fifo
// Purpose  : Small in-order buffer for displaced ALU results. Each entry has
//            a live bit; a squash request kills every entry whose destination
//            matches, so an older queued ALU result never overwrites a newer
//            load. Dead entries still occupy a slot until popped.
// Config   : WB_PENDING_MASK_EN - when defined, pending_mask is the OR of the
//            destinations of all live entries; otherwise it is tied to zero.
// Ports    : clk, rst (async, active-high)
//            push/push_live/push_dest/push_data - write tail entry
//            pop                                - retire head entry
//            squash/squash_dest                 - kill entries by destination
//            empty, full                        - occupancy flags
//            head_live/head_dest/head_data      - current head entry
//            pending_mask                       - live-destination bitmap
// Revision : 1.0  initial release
// ============================================================================
module wb_squash_fifo
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int REG_AW     = WB_REG_AW,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 push_live,
    input  logic [REG_AW-1:0]    push_dest,
    input  logic [DATA_W-1:0]    push_data,
    input  logic                 pop,
    input  logic                 squash,
    input  logic [REG_AW-1:0]    squash_dest,
    output logic                 empty,
    output logic                 full,
    output logic                 head_live,
    output logic [REG_AW-1:0]    head_dest,
    output logic [DATA_W-1:0]    head_data,
    output logic [2**REG_AW-1:0] pending_mask
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [FIFO_DEPTH-1:0] live;
    logic [REG_AW-1:0]     dest [FIFO_DEPTH];
    logic [DATA_W-1:0]     data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign head_live = live[rd_ptr];
    assign head_dest = dest[rd_ptr];
    assign head_data = data[rd_ptr];

    // Control state and live bits reset asynchronously so an abort empties
    // the buffer and clears pending status at once. A popped slot has its
    // live bit cleared, so only occupied slots can ever be live; this lets
    // pending_mask scan every slot without an occupancy window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (squash) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (dest[i] == squash_dest) begin
                        live[i] <= 1'b0;
                    end
                end
            end
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + 1'b1;
            end
            // Push comes last: its live bit already accounts for a same-cycle
            // squash, so it must override the loop above for its own slot.
            if (push) begin
                live[wr_ptr] <= push_live;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; the live bits gate its meaning.
    always_ff @(posedge clk) begin
        if (push) begin
            dest[wr_ptr] <= push_dest;
            data[wr_ptr] <= push_data;
        end
    end

`ifdef WB_PENDING_MASK_EN
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (live[i]) begin
                pending_mask[dest[i]] = 1'b1;
            end
        end
    end
`else
    assign pending_mask = '0;
`endif

endmodule : wb_squash_fifo
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_arbiter
// Purpose  : Owns the single register-file write port. Each cycle selects one
//            of: a load response, the head of the ALU result buffer, or a
//            bypassed ALU result, and registers it onto the write port.
//            ALU results that lose arbitration are queued; loads squash
//            older queued results aimed at the same register.
// Config   : WB_PENDING_MASK_EN - enables the per-register pending bitmap;
//            when undefined pending_mask is constant zero.
// Ports    : clk, rst (async, active-high)
//            alu_valid/alu_dest/alu_data/alu_ready - ALU producer (handshake)
//            ld_valid/ld_dest/ld_data              - load producer (no stall)
//            wb_en/wb_dest/wb_data                 - registered write port
//            pending_mask                          - live queued destinations
// Revision : 1.0  initial release
// ============================================================================
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int REG_AW     = WB_REG_AW,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [REG_AW-1:0]    alu_dest,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 ld_valid,
    input  logic [REG_AW-1:0]    ld_dest,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 wb_en,
    output logic [REG_AW-1:0]    wb_dest,
    output logic [DATA_W-1:0]    wb_data,
    output logic [2**REG_AW-1:0] pending_mask
);

    localparam logic [REG_AW-1:0] PC_DEST = REG_AW'(PC_REG);

    logic              fifo_empty;
    logic              fifo_full;
    logic              head_live;
    logic [REG_AW-1:0] head_dest;
    logic [DATA_W-1:0] head_data;

    logic              alu_acc;
    logic              pop;
    logic              push;
    logic              push_live;
    logic              sel_en;
    logic [REG_AW-1:0] sel_dest;
    logic [DATA_W-1:0] sel_data;

    // Readiness looks only at current occupancy: a full buffer refuses a
    // push even in a cycle where it is also popping.
    assign alu_ready = !fifo_full;
    assign alu_acc   = alu_valid & alu_ready;

    // A result headed to the PC is never written, so it is queued dead and
    // never shows in the pending bitmap. A result aimed at the register a
    // load is writing this cycle is older than that load and is also dead.
    assign push_live = (alu_dest != PC_DEST) && !(ld_valid && (alu_dest == ld_dest));

    always_comb begin
        sel_en   = 1'b0;
        sel_dest = wb_dest;
        sel_data = wb_data;
        pop      = 1'b0;
        push     = 1'b0;
        if (ld_valid) begin
            sel_en   = (ld_dest != PC_DEST);
            sel_dest = ld_dest;
            sel_data = ld_data;
            push     = alu_acc;
        end else if (!fifo_empty) begin
            pop      = 1'b1;
            sel_en   = head_live && (head_dest != PC_DEST);
            sel_dest = head_dest;
            sel_data = head_data;
            push     = alu_acc;
        end else if (alu_acc) begin
            sel_en   = (alu_dest != PC_DEST);
            sel_dest = alu_dest;
            sel_data = alu_data;
        end
    end

    wb_squash_fifo #(
        .DATA_W     (DATA_W),
        .REG_AW     (REG_AW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_live    (push_live),
        .push_dest    (alu_dest),
        .push_data    (alu_data),
        .pop          (pop),
        .squash       (ld_valid),
        .squash_dest  (ld_dest),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .head_live    (head_live),
        .head_dest    (head_dest),
        .head_data    (head_data),
        .pending_mask (pending_mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_dest <= '0;
            wb_data <= '0;
        end else begin
            wb_en   <= sel_en;
            wb_dest <= sel_dest;
            wb_data <= sel_data;
        end
    end

endmodule : wb_write_arbiter
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_write_arbiter
// Purpose  : Self-checking bench for wb_write_arbiter. A queue-based model of
//            the write-back rules predicts each registered write, alu_ready
//            and the pending bitmap; directed scenarios plus a randomized run.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_write_arbiter;

    localparam int DEPTH = 4;
`ifdef WB_PENDING_MASK_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_dest;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [3:0]  ld_dest;
    logic [31:0] ld_data;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic [15:0] pending_mask;

    wb_write_arbiter #(
        .DATA_W     (32),
        .REG_AW     (4),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_dest     (alu_dest),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .ld_valid     (ld_valid),
        .ld_dest      (ld_dest),
        .ld_data      (ld_data),
        .wb_en        (wb_en),
        .wb_dest      (wb_dest),
        .wb_data      (wb_data),
        .pending_mask (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        live;
        logic [3:0]  dest;
        logic [31:0] data;
    } mentry_t;

    mentry_t     mq[$];
    logic        exp_en;
    logic [3:0]  exp_dest;
    logic [31:0] exp_data;
    logic        exp_ready;
    logic        seen_ready;
    int          n_cmp;
    int          n_err;

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        m = '0;
        if (MASK_ON) begin
            foreach (mq[i]) if (mq[i].live) m[mq[i].dest] = 1'b1;
        end
        return m;
    endfunction

    // Drives one cycle of stimulus, advances the model, returns #1 after the
    // rising edge with exp_* holding the write the DUT should now present.
    task automatic do_cycle(input logic av, input logic [3:0] ad, input logic [31:0] adat,
                            input logic lv, input logic [3:0] ldd, input logic [31:0] ldat);
        logic    acc;
        mentry_t e;
        alu_valid = av; alu_dest = ad; alu_data = adat;
        ld_valid  = lv; ld_dest  = ldd; ld_data = ldat;
        #1;
        seen_ready = alu_ready;
        exp_ready  = (mq.size() < DEPTH);
        acc        = av && exp_ready;
        exp_en     = 1'b0;
        exp_dest   = 4'd0;
        exp_data   = 32'd0;
        if (lv) begin
            exp_en = (ldd != 4'd15); exp_dest = ldd; exp_data = ldat;
            foreach (mq[i]) if (mq[i].dest == ldd) mq[i].live = 1'b0;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            exp_en = e.live && (e.dest != 4'd15); exp_dest = e.dest; exp_data = e.data;
        end else if (acc) begin
            exp_en = (ad != 4'd15); exp_dest = ad; exp_data = adat;
            acc = 1'b0;
        end
        if (acc) begin
            e.live = (ad != 4'd15) && !(lv && ad == ldd);
            e.dest = ad; e.data = adat;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alu_valid = 0; alu_dest = 0; alu_data = 0;
        ld_valid = 0; ld_dest = 0; ld_data = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL reset_wb_en got=%b want=0", wb_en); end
        n_cmp++; if (wb_dest !== 4'd0 || wb_data !== 32'd0) begin n_err++; $display("FAIL reset_wb_addr_data got=%h/%h want=0/0", wb_dest, wb_data); end
        n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", alu_ready); end
        n_cmp++; if (pending_mask !== 16'h0) begin n_err++; $display("FAIL reset_mask got=%h want=0", pending_mask); end
        @(negedge clk) rst = 1'b0;
        // Queue three entries behind loads, then reset between edges.
        do_cycle(1, 4'd2, 32'h22, 1, 4'd1, 32'h11);
        do_cycle(1, 4'd4, 32'h44, 1, 4'd3, 32'h33);
        do_cycle(1, 4'd6, 32'h66, 1, 4'd5, 32'h55);
        n_cmp++; if (wb_en !== 1'b1 || wb_dest !== 4'd5) begin n_err++; $display("FAIL prereset_write got=%b/%h want=1/5", wb_en, wb_dest); end
        n_cmp++; if (pending_mask !== model_mask()) begin n_err++; $display("FAIL prereset_mask got=%h want=%h", pending_mask, model_mask()); end
        #2 rst = 1'b1;
        #1;
        mq.delete();
        n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL async_reset_wb_en got=%b want=0", wb_en); end
        n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL async_reset_ready got=%b want=1", alu_ready); end
        n_cmp++; if (pending_mask !== 16'h0) begin n_err++; $display("FAIL async_reset_mask got=%h want=0", pending_mask); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_cycle(0, 0, 0, 0, 0, 0);
            n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL post_reset_write cyc=%0d got=%b want=0", k, wb_en); end
        end
    endtask

    task automatic test_bypass();
        do_cycle(1, 4'd3, 32'hDEAD_BEEF, 0, 0, 0);
        n_cmp++; if (seen_ready !== 1'b1) begin n_err++; $display("FAIL bypass_ready got=%b want=1", seen_ready); end
        n_cmp++; if (wb_en !== 1'b1 || wb_dest !== 4'd3 || wb_data !== 32'hDEAD_BEEF)
            begin n_err++; $display("FAIL bypass_write got=%b/%h/%h want=1/3/deadbeef", wb_en, wb_dest, wb_data); end
        n_cmp++; if (pending_mask !== 16'h0) begin n_err++; $display("FAIL bypass_mask got=%h want=0", pending_mask); end
        do_cycle(0, 0, 0, 0, 0, 0);
        n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL bypass_idle got=%b want=0", wb_en); end
    endtask

    task automatic test_contention();
        do_cycle(1, 4'd2, 32'h22, 1, 4'd1, 32'h11);
        n_cmp++; if (wb_en !== 1'b1 || wb_dest !== 4'd1 || wb_data !== 32'h11)
            begin n_err++; $display("FAIL contend_load got=%b/%h/%h want=1/1/11", wb_en, wb_dest, wb_data); end
        n_cmp++; if (pending_mask !== (MASK_ON ? 16'h0004 : 16'h0))
            begin n_err++; $display("FAIL contend_mask got=%h want=%h", pending_mask, MASK_ON ? 16'h0004 : 16'h0); end
        do_cycle(0, 0, 0, 0, 0, 0);
        n_cmp++; if (wb_en !== 1'b1 || wb_dest !== 4'd2 || wb_data !== 32'h22)
            begin n_err++; $display("FAIL contend_alu got=%b/%h/%h want=1/2/22", wb_en, wb_dest, wb_data); end
        n_cmp++; if (pending_mask !== 16'h0) begin n_err++; $display("FAIL contend_mask_drain got=%h want=0", pending_mask); end
    endtask

    task automatic test_full();
        for (int k = 1; k <= 6; k++) begin
            do_cycle(1, 4'(k), 32'h100 + 32'(k), 1, 4'd8, 32'h80 + 32'(k));
            n_cmp++; if (seen_ready !== (k <= DEPTH))
                begin n_err++; $display("FAIL full_ready cyc=%0d got=%b want=%b", k, seen_ready, k <= DEPTH); end
            n_cmp++; if (wb_en !== 1'b1 || wb_dest !== 4'd8 || wb_data !== 32'h80 + 32'(k))
                begin n_err++; $display("FAIL full_load cyc=%0d got=%b/%h/%h", k, wb_en, wb_dest, wb_data); end
        end
        for (int k = 1; k <= DEPTH; k++) begin
            do_cycle(0, 0, 0, 0, 0, 0);
            n_cmp++; if (wb_en !== 1'b1 || wb_dest !== 4'(k) || wb_data !== 32'h100 + 32'(k))
                begin n_err++; $display("FAIL full_drain idx=%0d got=%b/%h/%h want=1/%h/%h", k, wb_en, wb_dest, wb_data, k, 32'h100 + k); end
        end
        do_cycle(0, 0, 0, 0, 0, 0);
        n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL full_empty got=%b want=0", wb_en); end
    endtask

    task automatic test_squash();
        do_cycle(1, 4'd5, 32'h55, 1, 4'd7, 32'h77);
        n_cmp++; if (pending_mask !== (MASK_ON ? 16'h0020 : 16'h0))
            begin n_err++; $display("FAIL squash_mask_set got=%h", pending_mask); end
        do_cycle(0, 0, 0, 1, 4'd5, 32'hAA);
        n_cmp++; if (wb_en !== 1'b1 || wb_dest !== 4'd5 || wb_data !== 32'hAA)
            begin n_err++; $display("FAIL squash_load got=%b/%h/%h want=1/5/aa", wb_en, wb_dest, wb_data); end
        n_cmp++; if (pending_mask !== 16'h0) begin n_err++; $display("FAIL squash_mask_clear got=%h want=0", pending_mask); end
        do_cycle(0, 0, 0, 0, 0, 0);
        n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL squash_dead_pop got=%b want=0", wb_en); end
        do_cycle(1, 4'd9, 32'h99, 0, 0, 0);
        n_cmp++; if (wb_en !== 1'b1 || wb_dest !== 4'd9)
            begin n_err++; $display("FAIL squash_after got=%b/%h want=1/9", wb_en, wb_dest); end
    endtask

    task automatic test_pc_drop();
        do_cycle(1, 4'd15, 32'hF00D, 0, 0, 0);
        n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL pc_bypass got=%b want=0", wb_en); end
        do_cycle(1, 4'd15, 32'hF00D, 1, 4'd1, 32'h1);
        n_cmp++; if (pending_mask !== 16'h0) begin n_err++; $display("FAIL pc_mask got=%h want=0", pending_mask); end
        do_cycle(0, 0, 0, 0, 0, 0);
        n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL pc_pop got=%b want=0", wb_en); end
        do_cycle(1, 4'd4, 32'h4, 0, 0, 0);
        n_cmp++; if (wb_en !== 1'b1 || wb_dest !== 4'd4)
            begin n_err++; $display("FAIL pc_consumed got=%b/%h want=1/4", wb_en, wb_dest); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            do_cycle(($urandom_range(0, 99) < 65), 4'($urandom_range(0, 15)), $urandom,
                     ($urandom_range(0, 99) < 40), 4'($urandom_range(0, 15)), $urandom);
            n_cmp++; if (seen_ready !== exp_ready)
                begin n_err++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", k, seen_ready, exp_ready); end
            n_cmp++; if (wb_en !== exp_en)
                begin n_err++; $display("FAIL rand_wb_en cyc=%0d got=%b want=%b", k, wb_en, exp_en); end
            if (exp_en) begin
                n_cmp++; if (wb_dest !== exp_dest || wb_data !== exp_data)
                    begin n_err++; $display("FAIL rand_write cyc=%0d got=%h/%h want=%h/%h", k, wb_dest, wb_data, exp_dest, exp_data); end
            end
            n_cmp++; if (pending_mask !== model_mask())
                begin n_err++; $display("FAIL rand_mask cyc=%0d got=%h want=%h", k, pending_mask, model_mask()); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_bypass();
        test_contention();
        test_full();
        test_squash();
        test_pc_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_wb_write_arbiter
`default_nettype wire
